// File: rtl/ifetch_unit_if.sv
// Instruction memory bus between the fetch unit and instruction memory.
// The fetch unit holds imem_req with a stable imem_addr until memory
// answers with imem_ack, which qualifies imem_rdata for that cycle.
//   imem_req    master -> slave   request valid
//   imem_addr   master -> slave   word address (low two bits always 0)
//   imem_ack    slave  -> master  response valid
//   imem_rdata  slave  -> master  instruction word
interface ifetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage of the multi-cycle RV32I core.
// On PC_Write & IR_Write it fetches the word at pc over the imem bus,
// loads it into ir and advances pc by 4 (or to a held redirect target).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   PC_Write, IR_Write     fetch strobes; a fetch starts only when both are high
//   pc_load, pc_load_val   jump/branch redirect request and target
//   imem                   instruction memory bus (master side)
//   pc, ir                 program counter and instruction register
//   opcode..rd             combinational field slices of ir
//   fetch_busy             high while a request is outstanding
//   fetch_done             one-cycle pulse, the cycle after ir was loaded
//   bus_err                sticky, memory did not answer within TIMEOUT cycles
//   misalign               sticky, a redirect target had nonzero low bits
//
// state | meaning
// IDLE  | waiting for a fetch strobe; redirects update pc directly
// REQ   | request outstanding at pc; redirects are held as pending
// ERR   | bus timeout seen; everything ignored until reset
module ifetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PC_Write,
    input  logic             IR_Write,
    input  logic             pc_load,
    input  logic [XLEN-1:0]  pc_load_val,
    ifetch_unit_if.master    imem,
    output logic [XLEN-1:0]  pc,
    output logic [31:0]      ir,
    output logic [6:0]       opcode,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic             fetch_busy,
    output logic             fetch_done,
    output logic             bus_err,
    output logic             misalign
);
    localparam int unsigned        CNT_W    = $clog2(TIMEOUT);
    // Down-counter of REQ cycles left before timeout; terminal count is 0.
    localparam logic [CNT_W-1:0]   TMO_LOAD = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0]        NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic             pend_vld_q, pend_vld_d;
    logic [XLEN-1:0]  pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             ir_loaded_q, ir_loaded_d;
    logic             fetch_done_q, fetch_done_d;
    logic             bus_err_q, bus_err_d;
    logic             misalign_q, misalign_d;

    logic             fetch_start;
    logic [XLEN-1:0]  load_pc;
    logic             load_misaligned;

    assign fetch_start     = PC_Write & IR_Write;
    assign load_pc         = {pc_load_val[XLEN-1:2], 2'b00};
    assign load_misaligned = |pc_load_val[1:0];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        pend_vld_d   = pend_vld_q;
        pend_pc_d    = pend_pc_q;
        tmo_cnt_d    = tmo_cnt_q;
        ir_loaded_d  = 1'b0;
        fetch_done_d = ir_loaded_q;
        bus_err_d    = bus_err_q;
        misalign_d   = misalign_q;

        unique case (state_q)
            IDLE: begin
                tmo_cnt_d  = TMO_LOAD;
                pend_vld_d = 1'b0;
                // A redirect in the strobe cycle lands in pc first, so the
                // request that follows already issues the new address.
                if (pc_load) begin
                    pc_d       = load_pc;
                    misalign_d = misalign_q | load_misaligned;
                end
                if (fetch_start) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (pc_load) begin
                    pend_vld_d = 1'b1;
                    pend_pc_d  = load_pc;
                    misalign_d = misalign_q | load_misaligned;
                end
                if (imem.imem_ack) begin
                    ir_d        = imem.imem_rdata;
                    // Uses the _d copies so a redirect in the ack cycle wins.
                    pc_d        = pend_vld_d ? pend_pc_d : pc_q + XLEN'(4);
                    pend_vld_d  = 1'b0;
                    ir_loaded_d = 1'b1;
                    state_d     = IDLE;
                end else if (tmo_cnt_q == '0) begin
                    bus_err_d = 1'b1;
                    state_d   = ERR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            ir_q         <= NOP;
            pend_vld_q   <= 1'b0;
            pend_pc_q    <= '0;
            tmo_cnt_q    <= TMO_LOAD;
            ir_loaded_q  <= 1'b0;
            fetch_done_q <= 1'b0;
            bus_err_q    <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            pend_vld_q   <= pend_vld_d;
            pend_pc_q    <= pend_pc_d;
            tmo_cnt_q    <= tmo_cnt_d;
            ir_loaded_q  <= ir_loaded_d;
            fetch_done_q <= fetch_done_d;
            bus_err_q    <= bus_err_d;
            misalign_q   <= misalign_d;
        end
    end

    assign imem.imem_req  = (state_q == REQ);
    assign imem.imem_addr = pc_q;

    assign pc         = pc_q;
    assign ir         = ir_q;
    assign opcode     = ir_q[6:0];
    assign rd         = ir_q[11:7];
    assign funct3     = ir_q[14:12];
    assign rs1        = ir_q[19:15];
    assign rs2        = ir_q[24:20];
    assign funct7     = ir_q[31:25];
    assign fetch_busy = (state_q == REQ);
    assign fetch_done = fetch_done_q;
    assign bus_err    = bus_err_q;
    assign misalign   = misalign_q;
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit. Each fetch pushes its expected address,
// instruction and next pc into a scoreboard; the entry is popped and
// compared when fetch_done pulses.
module tb_ifetch_unit;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned TIMEOUT = 16;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PC_Write = 1'b0;
    logic        IR_Write = 1'b0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_load_val = 32'h0;
    logic [31:0] pc, ir;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic        fetch_busy, fetch_done, bus_err, misalign;

    ifetch_unit_if #(.XLEN(XLEN)) imem_bus ();

    ifetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .PC_Write    (PC_Write),
        .IR_Write    (IR_Write),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .imem        (imem_bus),
        .pc          (pc),
        .ir          (ir),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .fetch_busy  (fetch_busy),
        .fetch_done  (fetch_done),
        .bus_err     (bus_err),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        logic [31:0] next_pc;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One fetch at model_pc. Memory acks after 'delay' extra REQ cycles.
    // If redir is set, a pc_load of rval is issued in the first REQ cycle.
    task automatic do_fetch(input logic [31:0] word, input int delay,
                            input bit redir, input logic [31:0] rval);
        exp_t e, got;
        e.addr    = model_pc;
        e.word    = word;
        e.next_pc = redir ? {rval[31:2], 2'b00} : model_pc + 32'd4;
        sb.push_back(e);
        PC_Write = 1'b1;
        IR_Write = 1'b1;
        tick();
        PC_Write = 1'b0;
        IR_Write = 1'b0;
        pc_load  = 1'b0;
        for (int i = 0; i <= delay; i++) begin
            check("req_high", {31'b0, imem_bus.imem_req}, 32'd1);
            check("addr_stable", imem_bus.imem_addr, e.addr);
            check("busy_high", {31'b0, fetch_busy}, 32'd1);
            if (i == 0 && redir) begin
                pc_load     = 1'b1;
                pc_load_val = rval;
            end
            if (i == delay) begin
                imem_bus.imem_ack   = 1'b1;
                imem_bus.imem_rdata = word;
            end
            tick();
            pc_load             = 1'b0;
            imem_bus.imem_ack   = 1'b0;
            imem_bus.imem_rdata = 32'hDEAD_BEEF;
        end
        check("ir_at_ack", ir, e.word);
        check("pc_at_ack", pc, e.next_pc);
        check("req_dropped", {31'b0, imem_bus.imem_req}, 32'd0);
        check("done_not_yet", {31'b0, fetch_done}, 32'd0);
        tick();
        check("done_pulse", {31'b0, fetch_done}, 32'd1);
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check("sb_ir", ir, got.word);
            check("sb_pc", pc, got.next_pc);
        end
        tick();
        check("done_one_cycle", {31'b0, fetch_done}, 32'd0);
        model_pc = e.next_pc;
    endtask

    task automatic check_reset_state();
        check("rst_pc", pc, 32'h0);
        check("rst_ir", ir, NOP);
        check("rst_req", {31'b0, imem_bus.imem_req}, 32'd0);
        check("rst_done", {31'b0, fetch_done}, 32'd0);
        check("rst_bus_err", {31'b0, bus_err}, 32'd0);
        check("rst_misalign", {31'b0, misalign}, 32'd0);
        check("rst_busy", {31'b0, fetch_busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_pc = 32'h0;
        check_reset_state();

        // Single strobes must not start a fetch.
        PC_Write = 1'b1;
        tick();
        PC_Write = 1'b0;
        check("pcw_only_req", {31'b0, imem_bus.imem_req}, 32'd0);
        IR_Write = 1'b1;
        tick();
        IR_Write = 1'b0;
        check("irw_only_req", {31'b0, imem_bus.imem_req}, 32'd0);

        // addi x1, x0, 5 with immediate ack.
        do_fetch(32'h0050_0093, 0, 1'b0, 32'h0);
        check("opcode", {25'b0, opcode}, 32'h13);
        check("rd", {27'b0, rd}, 32'd1);
        check("funct3", {29'b0, funct3}, 32'd0);
        check("rs1", {27'b0, rs1}, 32'd0);
        check("imm_rs2", {27'b0, rs2}, 32'd5);

        // add x2, x1, x2 with 5 wait cycles.
        do_fetch(32'h0020_8133, 5, 1'b0, 32'h0);
        check("funct7", {25'b0, funct7}, 32'h0);
        check("rs2", {27'b0, rs2}, 32'd2);
        check("rs1_add", {27'b0, rs1}, 32'd1);
        check("no_bus_err", {31'b0, bus_err}, 32'd0);

        // Redirect to 0x40 while fetching at pc=8.
        do_fetch(32'h0000_006F, 2, 1'b1, 32'h0000_0040);
        check("pc_redirected", pc, 32'h0000_0040);
        check("no_misalign", {31'b0, misalign}, 32'd0);

        // Misaligned redirect in IDLE.
        pc_load     = 1'b1;
        pc_load_val = 32'h0000_0102;
        tick();
        pc_load = 1'b0;
        model_pc = 32'h0000_0100;
        check("idle_load_pc", pc, 32'h0000_0100);
        check("misalign_set", {31'b0, misalign}, 32'd1);
        do_fetch(32'h0011_8193, 1, 1'b0, 32'h0);
        check("misalign_sticky", {31'b0, misalign}, 32'd1);

        // Redirect together with the fetch strobe.
        pc_load     = 1'b1;
        pc_load_val = 32'h0000_0200;
        model_pc    = 32'h0000_0200;
        do_fetch(32'h0000_0033, 0, 1'b0, 32'h0);

        // PC wrap.
        pc_load     = 1'b1;
        pc_load_val = 32'hFFFF_FFFC;
        tick();
        pc_load  = 1'b0;
        model_pc = 32'hFFFF_FFFC;
        do_fetch(32'h0000_0013, 0, 1'b0, 32'h0);
        check("pc_wrapped", pc, 32'h0);

        // Reset mid-request, then a late ack.
        PC_Write = 1'b1;
        IR_Write = 1'b1;
        tick();
        PC_Write = 1'b0;
        IR_Write = 1'b0;
        check("midreq_req", {31'b0, imem_bus.imem_req}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'hFFFF_FFFF;
        tick();
        imem_bus.imem_ack = 1'b0;
        check_reset_state();
        tick();
        check("late_ack_done", {31'b0, fetch_done}, 32'd0);
        check("late_ack_ir", ir, NOP);
        model_pc = 32'h0;

        // Timeout: no ack for TIMEOUT REQ cycles.
        PC_Write = 1'b1;
        IR_Write = 1'b1;
        tick();
        PC_Write = 1'b0;
        IR_Write = 1'b0;
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            check("tmo_req_high", {31'b0, imem_bus.imem_req}, 32'd1);
            check("tmo_bus_err_low", {31'b0, bus_err}, 32'd0);
            tick();
        end
        check("err_req_low", {31'b0, imem_bus.imem_req}, 32'd0);
        check("err_bus_err", {31'b0, bus_err}, 32'd1);
        check("err_busy_low", {31'b0, fetch_busy}, 32'd0);
        check("err_pc_kept", pc, model_pc);
        check("err_ir_kept", ir, NOP);
        PC_Write    = 1'b1;
        IR_Write    = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = 32'h0000_0081;
        tick();
        tick();
        PC_Write = 1'b0;
        IR_Write = 1'b0;
        pc_load  = 1'b0;
        check("err_strobe_ignored", {31'b0, imem_bus.imem_req}, 32'd0);
        check("err_load_ignored", pc, model_pc);
        check("err_no_misalign", {31'b0, misalign}, 32'd0);
        check("err_sticky", {31'b0, bus_err}, 32'd1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state();
        do_fetch(32'h0050_0093, 0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage of the multi-cycle RV32I core, directly upstream of the control unit. On the control unit's PC_Write/IR_Write fetch strobe it reads one word from instruction memory over a req/ack handshake, latches it into the instruction register and advances the PC by 4. It decodes the IR fields (opcode, funct3, funct7, rs1, rs2, rd) that feed the control unit and register file. It also supports a PC redirect for jumps and branches, and detects bus timeout and misaligned PC.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, PC value after reset
TIMEOUT, 16, max cycles in REQ waiting for imem_ack before bus error (>=2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
PC_Write  in  1  fetch strobe from control unit (PC update enable)
IR_Write  in  1  fetch strobe from control unit (IR load enable)
pc_load  in  1  redirect request (jump/branch target valid)
pc_load_val  in  XLEN  redirect target
imem_req  out  1  instruction memory request
imem_addr  out  XLEN  instruction memory word address
imem_ack  in  1  memory response valid, qualifies imem_rdata
imem_rdata  in  32  instruction word
pc  out  XLEN  current PC
ir  out  32  instruction register
opcode  out  7  ir[6:0]
funct3  out  3  ir[14:12]
funct7  out  7  ir[31:25]
rs1  out  5  ir[19:15]
rs2  out  5  ir[24:20]
rd  out  5  ir[11:7]
fetch_busy  out  1  high while in REQ
fetch_done  out  1  one-cycle pulse, cycle after IR load
bus_err  out  1  sticky, timeout occurred
misalign  out  1  sticky, redirect target had [1:0]!=0

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, pc=RESET_PC, ir=32'h0000_0013 (NOP), imem_req=0, fetch_done=0, bus_err=0, misalign=0, pending redirect cleared, timeout counter=0. Reset mid-REQ abandons the request; a late imem_ack after reset is ignored.
- Fetch start = PC_Write & IR_Write. Either strobe alone is ignored.
- States: IDLE, REQ, ERR.
- IDLE: fetch start -> REQ next cycle; counter cleared.
- REQ: imem_req=1, imem_addr=pc held stable; fetch_busy=1. Each cycle without ack, counter+1.
  - imem_ack=1: ir<=imem_rdata; pc<=pending redirect target if one is held, else pc+4 (mod 2^XLEN, wraps 32'hFFFF_FFFC -> 0); pending cleared; -> IDLE; fetch_done=1 on the following cycle only.
  - Counter reaches TIMEOUT-1 with no ack: -> ERR, bus_err<=1; ir and pc unchanged.
- ERR: imem_req=0; all fetch starts ignored; leaves only via rst.
- Latency: request is visible 1 cycle after fetch start; ir/pc are updated at the ack edge; fetch_done follows 1 cycle later. Minimum fetch start to fetch_done = 3 cycles with ack on the first REQ cycle.
- Redirect (pc_load):
  - IDLE: pc<=pc_load_val with bits[1:0] forced to 0.
  - Simultaneous with fetch start: load applies, and the REQ issues the new pc.
  - REQ: target is captured as pending; imem_addr is unchanged; pending is applied instead of +4 on ack; a later pc_load in the same REQ overwrites the pending target.
  - ERR: ignored.
  - pc_load_val[1:0]!=0: misalign<=1 (sticky); the address is still used with low bits forced to 0.
- Fetch start while in REQ: ignored (no queuing).
- Decoded fields are combinational slices of ir.

Test Plan:
- Reset then one fetch, imem_rdata=32'h00500093, ack on first REQ cycle -> imem_addr=0, ir=32'h00500093, opcode=7'h13, rd=1, pc=4, fetch_done one pulse 3 cycles after strobe.
- Ack delayed 5 cycles, TIMEOUT=16 -> imem_req high for 6 cycles with imem_addr stable, then normal completion; bus_err=0.
- No ack for 16 REQ cycles -> ERR, bus_err=1, imem_req=0; further strobes give no request until rst.
- pc_load=1, val=32'h0000_0102 in IDLE -> pc=32'h0000_0100, misalign=1; next fetch imem_addr=32'h100.
- pc_load val=32'h40 during REQ at pc=8 -> imem_addr stays 8; after ack pc=32'h40, not 32'hC.
- pc=32'hFFFF_FFFC, fetch with ack -> pc wraps to 0; rst asserted mid-REQ -> pc=RESET_PC, ir=NOP, late ack ignored.
